// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// fills the IF/ID register. Handles delayed branches, squashing redirects,
// stall-buffered redirects and address faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int unsigned MEM_BYTES  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_fault
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  // Redirect priorities; a higher value wins.
  localparam logic [1:0] PrioNone   = 2'd0;
  localparam logic [1:0] PrioBranch = 2'd1;
  localparam logic [1:0] PrioEret   = 2'd2;
  localparam logic [1:0] PrioExc    = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_squash_q, pend_squash_d;
  logic [1:0]  pend_prio_q, pend_prio_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_fault_q, id_fault_d;

  logic        pc_fault;
  logic [1:0]  req_prio;
  logic [31:0] req_target;
  logic        req_wins;
  logic        squash;

  assign pc_fault = (pc_q[1:0] != 2'b00) || (pc_q >= MEM_BYTES);

  // Pick the strongest redirect requested this cycle.
  always_comb begin
    req_prio   = PrioNone;
    req_target = pc_q;
    if (exc_req) begin
      req_prio   = PrioExc;
      req_target = EXC_VECTOR;
    end else if (eret_req) begin
      req_prio   = PrioEret;
      req_target = epc;
    end else if (branch_req) begin
      req_prio   = PrioBranch;
      req_target = branch_target;
    end
  end

  // A new request displaces a buffered one only at equal or higher priority.
  assign req_wins = (req_prio != PrioNone) && (!pend_valid_q || (req_prio >= pend_prio_q));

  // Next-state: FSM, PC, pending redirect and IF/ID register.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_squash_d = pend_squash_q;
    pend_prio_d   = pend_prio_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;
    id_fault_d    = id_fault_q;
    squash        = 1'b0;

    unique case (state_q)
      StBoot: state_d = StRun;
      StRun, StHold: begin
        if (stall) begin
          state_d = StHold;
          if (req_wins) begin
            pend_valid_d  = 1'b1;
            pend_target_d = req_target;
            pend_squash_d = (req_prio >= PrioEret);
            pend_prio_d   = req_prio;
          end
        end else begin
          state_d      = StRun;
          pend_valid_d = 1'b0;
          pend_prio_d  = PrioNone;
          if (req_wins) begin
            pc_d   = req_target;
            squash = (req_prio >= PrioEret);
          end else if (pend_valid_q) begin
            pc_d   = pend_target_q;
            squash = pend_squash_q;
          end else begin
            pc_d = pc_q + 32'd4;
          end
          if (squash) begin
            id_valid_d = 1'b0;
            id_inst_d  = '0;
            id_fault_d = 1'b0;
          end else begin
            // A faulted fetch still occupies the slot so AdEL reaches ID.
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_inst_d  = pc_fault ? '0 : inst_data;
            id_fault_d = pc_fault;
          end
        end
      end
      default: state_d = StBoot;
    endcase

    // flush bubbles IF/ID regardless of stall; the PC still follows stall.
    if (flush) begin
      id_valid_d = 1'b0;
      id_inst_d  = '0;
      id_fault_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_squash_q <= 1'b0;
      pend_prio_q   <= PrioNone;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_inst_q     <= '0;
      id_fault_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_squash_q <= pend_squash_d;
      pend_prio_q   <= pend_prio_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
      id_fault_q    <= id_fault_d;
    end
  end

  assign inst_addr = pc_q;
  assign inst_ce   = (state_q != StBoot) && !pc_fault;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_fault  = id_fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table plus randomized traffic,
// all checked against a behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_req, exc_req, eret_req;
  logic [31:0] branch_target, epc, inst_data, inst_addr, id_pc, id_inst;
  logic        inst_ce, id_valid, id_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_f025;
      32'h4:   return 32'h241d_1000;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign inst_data = mem_word(inst_addr);

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_req   (branch_req),
    .branch_target(branch_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .inst_ce      (inst_ce),
    .inst_addr    (inst_addr),
    .inst_data    (inst_data),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_fault     (id_fault)
  );

  // Behavioural model: a booted flag, the PC, an optional buffered redirect
  // (priority + target) and the IF/ID contents.
  bit          m_booted;
  logic [31:0] m_pc;
  bit          m_pend;
  int          m_pend_prio;
  logic [31:0] m_pend_tgt;
  bit          m_v, m_f;
  logic [31:0] m_idpc, m_inst;

  function automatic bit addr_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  task automatic model_step();
    int          rp;
    logic [31:0] rt;
    logic [31:0] tgt;
    bit          sq;
    if (rst) begin
      m_booted = 0; m_pc = 32'h0; m_pend = 0; m_pend_prio = 0;
      m_v = 0; m_idpc = 0; m_inst = 0; m_f = 0;
      return;
    end
    if (!m_booted) begin
      m_booted = 1;
    end else begin
      rp = 0; rt = 0;
      if (exc_req) begin rp = 3; rt = 32'h180; end
      else if (eret_req) begin rp = 2; rt = epc; end
      else if (branch_req) begin rp = 1; rt = branch_target; end
      if (stall) begin
        if (rp > 0 && (!m_pend || rp >= m_pend_prio)) begin
          m_pend = 1; m_pend_prio = rp; m_pend_tgt = rt;
        end
      end else begin
        if (rp > 0 && (!m_pend || rp >= m_pend_prio)) begin
          tgt = rt; sq = (rp >= 2);
        end else if (m_pend) begin
          tgt = m_pend_tgt; sq = (m_pend_prio >= 2);
        end else begin
          tgt = m_pc + 32'd4; sq = 0;
        end
        if (sq) begin
          m_v = 0; m_inst = 0; m_f = 0;
        end else begin
          m_v = 1; m_idpc = m_pc;
          m_f = addr_fault(m_pc);
          m_inst = m_f ? 32'h0 : mem_word(m_pc);
        end
        m_pc = tgt; m_pend = 0; m_pend_prio = 0;
      end
    end
    if (flush) begin
      m_v = 0; m_inst = 0; m_f = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_addr", inst_addr, m_pc);
    check("m_ce", 32'(inst_ce), 32'(m_booted && !addr_fault(m_pc)));
    check("m_valid", 32'(id_valid), 32'(m_v));
    if (m_v) check("m_idpc", id_pc, m_idpc);
    check("m_inst", id_inst, m_inst);
    check("m_fault", 32'(id_fault), 32'(m_f));
  endtask

  // Advance one clock edge with the current inputs, then compare to the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst, stall, flush, br;
    logic [31:0] bt;
    logic        exc, eret;
    logic [31:0] epc;
    logic [31:0] addr;
    logic        ce, v;
    logic [31:0] pc, inst;
    logic        f;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic fl, input logic b,
                     input logic [31:0] t, input logic x, input logic e, input logic [31:0] ep,
                     input logic [31:0] a, input logic ce, input logic v,
                     input logic [31:0] p, input logic [31:0] i, input logic f);
    vec_t w;
    w.rst = r; w.stall = s; w.flush = fl; w.br = b; w.bt = t; w.exc = x; w.eret = e;
    w.epc = ep; w.addr = a; w.ce = ce; w.v = v; w.pc = p; w.inst = i; w.f = f;
    vecs.push_back(w);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; branch_req = 0; branch_target = 0;
    exc_req = 0; eret_req = 0; epc = 0;

    // Columns: rst stall flush br bt exc eret epc | addr ce valid id_pc id_inst fault
    add(0,0,0,0,0,0,0,0,        32'h0,    1,0,0,      0,            0); // BOOT -> RUN
    add(0,0,0,0,0,0,0,0,        32'h4,    1,1,0,      32'h0000f025, 0);
    add(0,0,0,0,0,0,0,0,        32'h8,    1,1,32'h4,  32'h241d1000, 0);
    add(0,0,0,0,0,0,0,0,        32'hc,    1,1,32'h8,  32'ha5a50008, 0);
    add(0,0,0,0,0,0,0,0,        32'h10,   1,1,32'hc,  32'ha5a5000c, 0);
    add(0,0,0,1,32'h40,0,0,0,   32'h40,   1,1,32'h10, 32'ha5a50010, 0); // delay slot kept
    add(0,0,0,1,32'h20,0,0,0,   32'h20,   1,1,32'h40, 32'ha5a50040, 0);
    add(0,0,0,1,32'h300,1,0,0,  32'h180,  1,0,0,      0,            0); // exc beats branch
    add(0,0,0,0,0,0,0,0,        32'h184,  1,1,32'h180,32'ha5a50180, 0);
    add(0,0,0,0,0,0,1,32'h8,    32'h8,    1,0,0,      0,            0);
    add(0,1,0,1,32'h60,0,0,0,   32'h8,    1,0,0,      0,            0); // stall cycle 1
    add(0,1,0,0,0,0,1,32'h100,  32'h8,    1,0,0,      0,            0); // stall cycle 2
    add(0,1,0,0,0,0,0,0,        32'h8,    1,0,0,      0,            0); // stall cycle 3
    add(0,0,0,0,0,0,0,0,        32'h100,  1,0,0,      0,            0); // pending eret
    add(0,0,0,0,0,0,0,0,        32'h104,  1,1,32'h100,32'ha5a50100, 0);
    add(0,0,0,1,32'h1002,0,0,0, 32'h1002, 0,1,32'h104,32'ha5a50104, 0);
    add(0,0,0,0,0,0,0,0,        32'h1006, 0,1,32'h1002,0,           1); // AdEL
    add(0,0,0,1,32'h200,0,0,0,  32'h200,  1,1,32'h1006,0,           1);
    add(0,0,0,0,0,0,0,0,        32'h204,  1,1,32'h200,32'ha5a50200, 0);
    add(0,1,1,0,0,0,0,0,        32'h204,  1,0,0,      0,            0); // flush over stall
    add(0,1,0,1,32'h60,0,0,0,   32'h204,  1,0,0,      0,            0);
    add(1,1,0,0,0,0,0,0,        32'h0,    0,0,0,      0,            0); // rst in HOLD
    add(0,0,0,0,0,0,0,0,        32'h0,    1,0,0,      0,            0);
    add(0,0,0,0,0,0,0,0,        32'h4,    1,1,0,      32'h0000f025, 0); // pending dropped
    add(0,1,0,0,0,1,0,0,        32'h4,    1,1,0,      32'h0000f025, 0);
    add(0,1,0,1,32'h60,0,0,0,   32'h4,    1,1,0,      32'h0000f025, 0); // lower prio ignored
    add(0,0,0,0,0,0,1,32'h300,  32'h180,  1,0,0,      0,            0); // exit: eret loses
    add(0,0,0,0,0,0,0,0,        32'h184,  1,1,32'h180,32'ha5a50180, 0);
    add(0,1,0,1,32'h40,0,0,0,   32'h184,  1,1,32'h180,32'ha5a50180, 0);
    add(0,0,0,0,0,0,0,0,        32'h40,   1,1,32'h184,32'ha5a50184, 0); // pending branch

    // Reset edge: BOOT with chip enable low.
    tick();
    check("rst_ce", 32'(inst_ce), 32'h0);
    check("rst_addr", inst_addr, 32'h0);
    rst = 0;

    foreach (vecs[k]) begin
      rst = vecs[k].rst; stall = vecs[k].stall; flush = vecs[k].flush;
      branch_req = vecs[k].br; branch_target = vecs[k].bt;
      exc_req = vecs[k].exc; eret_req = vecs[k].eret; epc = vecs[k].epc;
      tick();
      check($sformatf("v%0d_addr", k), inst_addr, vecs[k].addr);
      check($sformatf("v%0d_ce", k), 32'(inst_ce), 32'(vecs[k].ce));
      check($sformatf("v%0d_valid", k), 32'(id_valid), 32'(vecs[k].v));
      if (vecs[k].v || vecs[k].rst) check($sformatf("v%0d_idpc", k), id_pc, vecs[k].pc);
      check($sformatf("v%0d_inst", k), id_inst, vecs[k].inst);
      check($sformatf("v%0d_fault", k), 32'(id_fault), 32'(vecs[k].f));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      branch_req = ($urandom_range(0, 4) == 0);
      exc_req    = ($urandom_range(0, 19) == 0);
      eret_req   = ($urandom_range(0, 11) == 0);
      branch_target = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023)) << 2;
      epc           = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023)) << 2;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
